// File: rtl/fetch_stage.sv
// rv32i instruction-fetch stage: owns the fetch PC, issues one imem
// request per instruction and loads the IF/ID pipeline register.
package rv32i_pkg;
   localparam int DPW = 32;
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0]    instr;
      logic [DPW-1:0] pc;
      logic [DPW-1:0] pc4;
      logic           valid;
   } if_id_t;
endpackage

module fetch_stage
   import rv32i_pkg::*;
#(
   parameter logic [DPW-1:0] RESET_PC = '0
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic [DPW-1:0] PCNext,
   input  logic           PCSrcE,
   input  logic           stall_i,
   output logic [DPW-1:0] PCF,
   output logic           imem_req_o,
   output logic [DPW-1:0] imem_addr_o,
   input  logic [31:0]    imem_rdata_i,
   input  logic           imem_rvalid_i,
   output logic [31:0]    InstrD,
   output logic [DPW-1:0] PCD,
   output logic [DPW-1:0] PCPlus4D,
   output logic           validD
);

   typedef enum logic [2:0] {
      BOOT,
      REQ,
      WAIT,
      DRAIN,
      HOLD
   } state_e;

   state_e         r_state;
   state_e         w_state_nxt;
   logic [DPW-1:0] r_pcf;
   logic [DPW-1:0] w_pcf_nxt;
   if_id_t         r_ifid;
   if_id_t         w_ifid_nxt;
   logic           r_hold_vld;
   logic           w_hold_vld_nxt;
   logic [31:0]    r_hold_instr;
   logic [31:0]    w_hold_instr_nxt;
   logic [DPW-1:0] r_hold_pc;
   logic [DPW-1:0] w_hold_pc_nxt;
   logic           w_rsp_pending;

   // An unanswered request is still in flight in WAIT/DRAIN.
   assign w_rsp_pending = (r_state == WAIT) || (r_state == DRAIN);

   always_comb begin
      w_state_nxt      = r_state;
      w_pcf_nxt        = r_pcf;
      w_ifid_nxt       = r_ifid;
      w_hold_vld_nxt   = r_hold_vld;
      w_hold_instr_nxt = r_hold_instr;
      w_hold_pc_nxt    = r_hold_pc;

      if (!stall_i) begin
         w_ifid_nxt.instr = NOP;
         w_ifid_nxt.valid = 1'b0;
      end

      if (PCSrcE) begin
         w_pcf_nxt        = PCNext;
         w_ifid_nxt.instr = NOP;
         w_ifid_nxt.valid = 1'b0;
         w_hold_vld_nxt   = 1'b0;
         if (w_rsp_pending && !imem_rvalid_i)
            w_state_nxt = DRAIN;
         else
            w_state_nxt = REQ;
      end else begin
         unique case (r_state)
            BOOT: w_state_nxt = REQ;
            REQ:  w_state_nxt = WAIT;
            WAIT: begin
               if (imem_rvalid_i && stall_i) begin
                  w_hold_vld_nxt   = 1'b1;
                  w_hold_instr_nxt = imem_rdata_i;
                  w_hold_pc_nxt    = r_pcf;
                  w_state_nxt      = HOLD;
               end else if (imem_rvalid_i) begin
                  w_ifid_nxt.instr = imem_rdata_i;
                  w_ifid_nxt.pc    = r_pcf;
                  w_ifid_nxt.pc4   = r_pcf + DPW'(4);
                  w_ifid_nxt.valid = 1'b1;
                  w_pcf_nxt        = PCNext;
                  w_state_nxt      = REQ;
               end
            end
            DRAIN: begin
               if (imem_rvalid_i)
                  w_state_nxt = REQ;
            end
            HOLD: begin
               if (!stall_i && r_hold_vld) begin
                  w_ifid_nxt.instr = r_hold_instr;
                  w_ifid_nxt.pc    = r_hold_pc;
                  w_ifid_nxt.pc4   = r_hold_pc + DPW'(4);
                  w_ifid_nxt.valid = 1'b1;
                  w_hold_vld_nxt   = 1'b0;
                  w_pcf_nxt        = PCNext;
                  w_state_nxt      = REQ;
               end else if (!r_hold_vld) begin
                  w_state_nxt = REQ;
               end
            end
            default: w_state_nxt = BOOT;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state      <= BOOT;
         r_pcf        <= RESET_PC;
         r_ifid.instr <= NOP;
         r_ifid.pc    <= '0;
         r_ifid.pc4   <= '0;
         r_ifid.valid <= 1'b0;
         r_hold_vld   <= 1'b0;
         r_hold_instr <= '0;
         r_hold_pc    <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_pcf        <= w_pcf_nxt;
         r_ifid       <= w_ifid_nxt;
         r_hold_vld   <= w_hold_vld_nxt;
         r_hold_instr <= w_hold_instr_nxt;
         r_hold_pc    <= w_hold_pc_nxt;
      end
   end

   assign PCF         = r_pcf;
   assign imem_req_o  = (r_state == REQ) && !PCSrcE;
   assign imem_addr_o = r_pcf;
   assign InstrD      = r_ifid.instr;
   assign PCD         = r_ifid.pc;
   assign PCPlus4D    = r_ifid.pc4;
   assign validD      = r_ifid.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: variable-latency imem model, random stall and
// redirect traffic, and a transaction-level model of the fetch rules.
module tb_fetch_stage;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n  = 1'b0;
   logic        stall  = 1'b0;
   logic        br     = 1'b0;
   logic        rvalid = 1'b0;
   logic [31:0] pcnext = '0;
   logic [31:0] rdata  = '0;
   logic [31:0] pcf, addr, instr_d, pc_d, pc4_d;
   logic        req, vld_d;

   fetch_stage #(.RESET_PC(32'h0)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .PCNext       (pcnext),
      .PCSrcE       (br),
      .stall_i      (stall),
      .PCF          (pcf),
      .imem_req_o   (req),
      .imem_addr_o  (addr),
      .imem_rdata_i (rdata),
      .imem_rvalid_i(rvalid),
      .InstrD       (instr_d),
      .PCD          (pc_d),
      .PCPlus4D     (pc4_d),
      .validD       (vld_d)
   );

   int checks = 0;
   int fails  = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string n, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] memw(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   // Memory: one response per request, after lat cycles (lat==0: random 1..4)
   typedef struct {
      logic [31:0] a;
      int          due;
   } mrsp_t;
   mrsp_t mq[$];
   int    cyc = 0;
   int    lat = 1;

   // Model: a fetch is either about to be requested, in flight (maybe
   // doomed by a redirect), or parked behind a stall.
   bit          m_boot, m_ready, m_busy, m_drop, m_held;
   logic [31:0] m_pc, h_ins, h_pc;
   logic [31:0] e_ins, e_pcd, e_pc4;
   logic        e_vld;

   always @(posedge clk) begin
      bit          dlv;
      logic [31:0] d_ins, d_pc;
      int          l;
      cyc++;
      if (rvalid && mq.size() > 0) void'(mq.pop_front());
      if (req === 1'b1) begin
         l = (lat == 0) ? int'($urandom_range(1, 4)) : lat;
         mq.push_back('{a: addr, due: cyc + l - 1});
      end
      dlv = 1'b0;
      d_ins = '0;
      d_pc = '0;
      if (!rst_n) begin
         m_boot = 1; m_ready = 0; m_busy = 0; m_drop = 0; m_held = 0;
         m_pc = 32'h0;
         e_ins = NOP; e_pcd = '0; e_pc4 = '0; e_vld = 1'b0;
      end else if (br) begin
         m_boot = 0;
         m_held = 0;
         if (m_busy && !rvalid) begin
            m_drop = 1; m_ready = 0;
         end else begin
            m_busy = 0; m_drop = 0; m_ready = 1;
         end
         m_pc = pcnext;
         e_ins = NOP;
         e_vld = 1'b0;
      end else begin
         if (m_boot) begin
            m_boot = 0; m_ready = 1;
         end else if (m_ready) begin
            m_ready = 0; m_busy = 1; m_drop = 0;
         end else if (m_busy && rvalid) begin
            m_busy = 0;
            if (m_drop) m_ready = 1;
            else if (stall) begin
               m_held = 1; h_ins = rdata; h_pc = m_pc;
            end else begin
               dlv = 1; d_ins = rdata; d_pc = m_pc;
            end
         end else if (m_held && !stall) begin
            m_held = 0; dlv = 1; d_ins = h_ins; d_pc = h_pc;
         end
         if (dlv) begin
            e_ins = d_ins; e_pcd = d_pc; e_pc4 = d_pc + 32'd4; e_vld = 1'b1;
            m_pc = pcnext;
            m_ready = 1;
         end else if (!stall) begin
            e_ins = NOP; e_vld = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("pcf", pcf, m_pc);
         chk("req", {31'b0, req}, {31'b0, m_ready && !br});
         chk("addr", addr, m_pc);
         chk("instr_d", instr_d, e_ins);
         chk("pc_d", pc_d, e_pcd);
         chk("pc4_d", pc4_d, e_pc4);
         chk("valid_d", {31'b0, vld_d}, {31'b0, e_vld});
      end
   end

   // Inputs set here apply to the cycle seen at the following negedge.
   task automatic tick(input logic r, input logic s, input logic b,
                       input logic [31:0] t);
      @(posedge clk);
      #1;
      rst_n  = r;
      stall  = s;
      br     = b;
      pcnext = b ? t : m_pc + 32'd4;
      rvalid = (mq.size() > 0) && (mq[0].due <= cyc);
      rdata  = rvalid ? memw(mq[0].a) : 32'hDEAD_BEEF;
      @(negedge clk);
   endtask

   initial begin
      int rst_left;
      lat = 1;
      tick(0, 0, 0, 0);
      tick(0, 0, 0, 0);
      chk_en = 1'b1;
      chk("rst_instr", instr_d, NOP);
      chk("rst_valid", {31'b0, vld_d}, 32'd0);
      chk("rst_pcf", pcf, 32'h0);
      chk("rst_req", {31'b0, req}, 32'd0);
      chk("rst_pcd", pc_d, 32'h0);

      // Boot and two 1-cycle fetches
      tick(1, 0, 0, 0);
      chk("boot_noreq", {31'b0, req}, 32'd0);
      tick(1, 0, 0, 0);
      chk("req0", {31'b0, req}, 32'd1);
      chk("req0_addr", addr, 32'h0);
      tick(1, 0, 0, 0);
      tick(1, 0, 0, 0);
      chk("i0_instr", instr_d, memw(32'h0));
      chk("i0_pcd", pc_d, 32'h0);
      chk("i0_pc4", pc4_d, 32'h4);
      chk("i0_valid", {31'b0, vld_d}, 32'd1);
      chk("i0_pcf", pcf, 32'h4);
      chk("req4_addr", addr, 32'h4);
      tick(1, 0, 0, 0);
      chk("i0_onecycle", {31'b0, vld_d}, 32'd0);
      tick(1, 0, 0, 0);
      chk("i1_pcd", pc_d, 32'h4);
      chk("i1_pcf", pcf, 32'h8);

      // Stall when the response for 8 arrives
      tick(1, 1, 0, 0);
      tick(1, 1, 0, 0);
      chk("hold_noreq", {31'b0, req}, 32'd0);
      chk("hold_pcd", pc_d, 32'h4);
      tick(1, 1, 0, 0);
      tick(1, 0, 0, 0);
      chk("hold_noreq2", {31'b0, req}, 32'd0);
      tick(1, 0, 0, 0);
      chk("rel_pcd", pc_d, 32'h8);
      chk("rel_instr", instr_d, memw(32'h8));
      chk("rel_valid", {31'b0, vld_d}, 32'd1);
      chk("rel_addr", addr, 32'hC);

      // Redirect to 0x100 while waiting on a 3-cycle memory
      lat = 3;
      tick(1, 0, 1, 32'h100);
      tick(1, 0, 0, 0);
      chk("drain_pcf", pcf, 32'h100);
      chk("drain_noreq", {31'b0, req}, 32'd0);
      tick(1, 0, 0, 0);
      tick(1, 0, 0, 0);
      chk("req100", {31'b0, req}, 32'd1);
      chk("req100_addr", addr, 32'h100);
      chk("drain_valid", {31'b0, vld_d}, 32'd0);
      tick(1, 0, 0, 0);
      tick(1, 0, 0, 0);
      tick(1, 0, 0, 0);
      chk("wait100_valid", {31'b0, vld_d}, 32'd0);
      tick(1, 0, 0, 0);
      chk("i100_pcd", pc_d, 32'h100);
      chk("i100_valid", {31'b0, vld_d}, 32'd1);

      // Redirect coinciding with a response
      lat = 1;
      tick(1, 0, 1, 32'h20);
      tick(1, 0, 0, 0);
      chk("req20_addr", addr, 32'h20);
      tick(1, 0, 1, 32'h40);
      tick(1, 0, 0, 0);
      chk("req40_addr", addr, 32'h40);
      chk("req40", {31'b0, req}, 32'd1);
      chk("br_discard_valid", {31'b0, vld_d}, 32'd0);

      // Redirect in REQ suppresses the request; wrap of PC+4
      tick(1, 0, 0, 0);
      tick(1, 0, 1, 32'hFFFF_FFFC);
      chk("br_req_suppr", {31'b0, req}, 32'd0);
      chk("i40_pcd", pc_d, 32'h40);
      tick(1, 0, 0, 0);
      chk("reqfffc_addr", addr, 32'hFFFF_FFFC);
      tick(1, 0, 0, 0);
      tick(1, 0, 0, 0);
      chk("wrap_pcd", pc_d, 32'hFFFF_FFFC);
      chk("wrap_pc4", pc4_d, 32'h0);
      chk("wrap_pcf", pcf, 32'h0);

      // Reset during WAIT, late response lands in BOOT
      lat = 3;
      tick(1, 0, 0, 0);
      tick(0, 0, 0, 0);
      tick(1, 0, 0, 0);
      chk("rstw_noreq", {31'b0, req}, 32'd0);
      chk("rstw_valid", {31'b0, vld_d}, 32'd0);
      tick(1, 0, 0, 0);
      chk("rstw_req", {31'b0, req}, 32'd1);
      chk("rstw_addr", addr, 32'h0);

      // Random traffic
      lat = 0;
      rst_left = 0;
      for (int i = 0; i < 3000; i++) begin
         logic        r, s, b;
         logic [31:0] t;
         r = 1'b1;
         if (rst_left > 0) begin
            r = 1'b0;
            rst_left--;
         end else if ($urandom_range(0, 299) == 0) begin
            r = 1'b0;
            rst_left = 4;
         end
         s = ($urandom_range(0, 3) == 0);
         b = ($urandom_range(0, 11) == 0);
         t = $urandom() & 32'hFFFF_FFFC;
         tick(r, s, b, t);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the rv32i pipeline. Holds the architectural fetch PC (`PCF`), issues one request per instruction to instruction memory, and loads the IF/ID pipeline register. It consumes `PCNext`/`PCSrcE` from the branch unit: `PCNext` is either `PCF+4` or the branch target. It honours stall from the hazard unit and flushes on a taken branch.

## Interface
- `DPW`, 32 (from `rv32i_pkg`): data/address width.
- `RESET_PC`, 32'h0000_0000: fetch address after reset.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset; synchronous, active-low.
- `PCNext`  in  DPW  next PC from the branch unit.
- `PCSrcE`  in  1  taken-branch redirect, qualified by the branch unit.
- `stall_i`  in  1  ID stage cannot accept; hold IF/ID.
- `PCF`  out  DPW  current fetch PC, fed to the branch unit.
- `imem_req_o`  out  1  one-cycle request pulse.
- `imem_addr_o`  out  DPW  request address; always equals `PCF`.
- `imem_rdata_i`  in  32  instruction word.
- `imem_rvalid_i`  in  1  response valid; arrives at least 1 cycle after its request, exactly once per request.
- `InstrD`  out  32  IF/ID instruction.
- `PCD`  out  DPW  IF/ID PC.
- `PCPlus4D`  out  DPW  IF/ID PC+4.
- `validD`  out  1  IF/ID holds a real instruction.

## Operation
- FSM states: BOOT, REQ, WAIT, DRAIN, HOLD. There is a 1-entry hold buffer (instr, PC).
- Reset (`rst_ni`=0 sampled at the edge):
  - state=BOOT, `PCF`=RESET_PC, hold buffer invalid.
  - `InstrD`=32'h0000_0013 (NOP), `PCD`=0, `PCPlus4D`=0, `validD`=0.
  - `imem_req_o`=0.
- Request output: `imem_req_o` = (state==REQ) && !`PCSrcE`.
- Per-state transitions:
  - BOOT: go to REQ next cycle.
  - REQ: go to WAIT.
  - WAIT, `imem_rvalid_i` && !`stall_i`: fetch completes. IF/ID <= {rdata, PCF, PCF+4, valid=1}; `PCF` <= `PCNext`; go to REQ.
  - WAIT, `imem_rvalid_i` && `stall_i`: capture {rdata, PCF} into the hold buffer; go to HOLD.
  - HOLD, !`stall_i`: IF/ID <= hold buffer with valid=1; `PCF` <= `PCNext`; go to REQ.
  - DRAIN: on `imem_rvalid_i`, discard the response and go to REQ.
- When there is no completion and !`stall_i`, IF/ID loads a bubble: NOP, `validD`=0, `PCD`/`PCPlus4D` unchanged.
- When `stall_i`=1, IF/ID holds its contents.
- Redirect (`PCSrcE`=1) has top priority, over stall and completion:
  - `PCF` <= `PCNext`.
  - IF/ID <= bubble.
  - Hold buffer is invalidated.
  - Next state: WAIT without rvalid -> DRAIN; WAIT with rvalid -> REQ (response discarded); DRAIN without rvalid -> DRAIN; all other cases -> REQ.
  - A redirect in REQ suppresses that cycle's request.
- Arithmetic: `PCPlus4D` = `PCF` + 4, modulo 2^DPW. 32'hFFFF_FFFC yields 0.
- `PCF` changes only on completion, on a HOLD release, or on redirect. It is therefore stable while a request is outstanding.

## Timing
- Throughput is one instruction per 2 cycles with a 1-cycle memory (REQ, WAIT).
- Latency from the request cycle to `validD`=1 is memory latency + 1 edge.
- The first request occurs in the 2nd cycle after reset release (BOOT occupies the 1st).
- `validD` is high for exactly one cycle per delivered instruction unless stalled. While stalled it stays high and is held.
- Reset asserted mid-WAIT or mid-DRAIN returns the block to BOOT. A late response arriving afterwards in BOOT or REQ is ignored.

## Test plan
- Reset release, RESET_PC=0, 1-cycle memory returning I0, then I1:
  - `imem_req_o` pulses with addr 0, then addr 4.
  - `InstrD`=I0, `PCD`=0, `PCPlus4D`=4, `validD`=1 one cycle.
  - `PCF`=4.
- `stall_i`=1 in the cycle rvalid arrives for addr 8, released 3 cycles later:
  - No request is issued while in HOLD.
  - IF/ID holds its prior contents.
  - After release, `PCD`=8, `validD`=1, and the next request is to 12.
- `PCSrcE`=1 with `PCNext`=0x100 while WAIT (memory latency 3):
  - FSM goes to DRAIN; the late response is discarded.
  - The next request is to 0x100; `validD` stays 0 until the 0x100 instruction arrives.
- `PCSrcE`=1 in the same cycle as rvalid for addr 0x20, `PCNext`=0x40:
  - The instruction is discarded; `validD`=0.
  - The next request is to 0x40.
- `PCF`=32'hFFFF_FFFC completes: `PCPlus4D`=0.
- `rst_ni`=0 during WAIT, response arrives during BOOT: the response is ignored, and the first request after reset goes to RESET_PC.
